// File: rtl/tcm_xbar_if.sv
// Bus bundle for tcm_xbar: the fetch and LSU request/response channels plus the ITCM and DTCM SRAM macro pins.
// The slave modport is the crossbar's view of the bundle; the master modport is the core/SRAM environment's view.
interface tcm_xbar_if #(
  parameter int ITCM_AW = 16,
  parameter int DTCM_AW = 16
) ();
  logic               if_req;
  logic [28:0]        if_addr;
  logic               if_gnt;
  logic               if_rvalid;
  logic [63:0]        if_rdata;

  logic               lsu_req;
  logic               lsu_we;
  logic [31:0]        lsu_addr;
  logic [3:0]         lsu_ben;
  logic [31:0]        lsu_wdata;
  logic               lsu_gnt;
  logic               lsu_rvalid;
  logic [31:0]        lsu_rdata;
  logic               lsu_err;

  logic               itcm_csn0;
  logic               itcm_csn1;
  logic               itcm_wen;
  logic [ITCM_AW-1:0] itcm_addr;
  logic [7:0]         itcm_ben;
  logic [63:0]        itcm_din;
  logic [63:0]        itcm_dout;

  logic               dtcm_csn;
  logic               dtcm_wen;
  logic [DTCM_AW-1:0] dtcm_addr;
  logic [3:0]         dtcm_ben;
  logic [31:0]        dtcm_din;
  logic [31:0]        dtcm_dout;

  modport slave (
    input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_ben, lsu_wdata,
           itcm_dout, dtcm_dout,
    output if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
           itcm_csn0, itcm_csn1, itcm_wen, itcm_addr, itcm_ben, itcm_din,
           dtcm_csn, dtcm_wen, dtcm_addr, dtcm_ben, dtcm_din
  );

  modport master (
    output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_ben, lsu_wdata,
           itcm_dout, dtcm_dout,
    input  if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
           itcm_csn0, itcm_csn1, itcm_wen, itcm_addr, itcm_ben, itcm_din,
           dtcm_csn, dtcm_wen, dtcm_addr, dtcm_ben, dtcm_din
  );
endinterface

// File: rtl/tcm_xbar.sv
// 2-master / 2-slave TCM crossbar: fetch and LSU onto ITCM (64-bit) and DTCM (32-bit) with starvation-bounded arbitration.
// Optional macro TCM_XBAR_ERR_EN: unmapped LSU accesses get an error response instead of aliasing to DTCM.
module tcm_xbar #(
  parameter int                BASE_W     = 8,
  parameter logic [BASE_W-1:0] ITCM_BASE  = 8'h80,
  parameter logic [BASE_W-1:0] DTCM_BASE  = 8'h90,
  parameter int                ITCM_AW    = 16,
  parameter int                DTCM_AW    = 16,
  parameter int                STARVE_MAX = 4
) (
  input logic        clk,
  input logic        cpurst,
  tcm_xbar_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_ITCM = 2'd0,
    SRC_DTCM = 2'd1,
    SRC_ERR  = 2'd2
  } src_e;

  logic [BASE_W-1:0] w_tag;
  logic              w_hitI;
  logic              w_dtcmTag;
  logic              w_hitD;
  logic              w_unmapped;
  logic              w_fetchWins;
  logic              w_ifGnt;
  logic              w_lsuGnt;
  logic              w_unused;

  logic [7:0]        r_starveCnt;
  logic              r_ifPend;
  logic              r_lsuPend;
  src_e              r_lsuSrc;
  logic              r_lsuHi;
  logic              r_lsuWr;

  assign w_tag     = bus.lsu_addr[31:32-BASE_W];
  assign w_hitI    = (w_tag == ITCM_BASE);
  assign w_dtcmTag = (w_tag == DTCM_BASE);

`ifdef TCM_XBAR_ERR_EN
  assign w_hitD     = w_dtcmTag;
  assign w_unmapped = !w_hitI && !w_dtcmTag;
`else
  // Anything that is not ITCM falls through to DTCM.
  assign w_hitD     = w_dtcmTag || !w_hitI;
  assign w_unmapped = 1'b0;
`endif

  assign w_unused = ^{bus.lsu_addr, bus.if_addr};

  assign w_fetchWins = bus.if_req && (r_starveCnt == 8'(STARVE_MAX));
  assign w_lsuGnt    = !cpurst && bus.lsu_req && !(w_hitI && w_fetchWins);
  assign w_ifGnt     = !cpurst && bus.if_req && !(bus.lsu_req && w_hitI && !w_fetchWins);

  assign bus.if_gnt  = w_ifGnt;
  assign bus.lsu_gnt = w_lsuGnt;

  // LSU and fetch grants onto ITCM are mutually exclusive, so the LSU branch can take priority.
  always_comb begin
    bus.itcm_csn0 = 1'b1;
    bus.itcm_csn1 = 1'b1;
    bus.itcm_wen  = 1'b1;
    bus.itcm_addr = '0;
    bus.itcm_ben  = '0;
    bus.itcm_din  = '0;
    if (w_lsuGnt && w_hitI) begin
      bus.itcm_csn0 = bus.lsu_addr[2];
      bus.itcm_csn1 = !bus.lsu_addr[2];
      bus.itcm_wen  = !bus.lsu_we;
      bus.itcm_addr = bus.lsu_addr[ITCM_AW+2:3];
      bus.itcm_ben  = bus.lsu_addr[2] ? {bus.lsu_ben, 4'h0} : {4'h0, bus.lsu_ben};
      bus.itcm_din  = {bus.lsu_wdata, bus.lsu_wdata};
    end else if (w_ifGnt) begin
      bus.itcm_csn0 = 1'b0;
      bus.itcm_csn1 = 1'b0;
      bus.itcm_addr = bus.if_addr[ITCM_AW-1:0];
      bus.itcm_ben  = 8'hff;
    end
  end

  always_comb begin
    bus.dtcm_csn  = 1'b1;
    bus.dtcm_wen  = 1'b1;
    bus.dtcm_addr = '0;
    bus.dtcm_ben  = '0;
    bus.dtcm_din  = '0;
    if (w_lsuGnt && w_hitD) begin
      bus.dtcm_csn  = 1'b0;
      bus.dtcm_wen  = !bus.lsu_we;
      bus.dtcm_addr = bus.lsu_addr[DTCM_AW+1:2];
      bus.dtcm_ben  = bus.lsu_ben;
      bus.dtcm_din  = bus.lsu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      r_ifPend    <= 1'b0;
      r_lsuPend   <= 1'b0;
      r_lsuSrc    <= SRC_ITCM;
      r_lsuHi     <= 1'b0;
      r_lsuWr     <= 1'b0;
      r_starveCnt <= '0;
    end else begin
      r_ifPend  <= w_ifGnt;
      r_lsuPend <= w_lsuGnt;
      if (w_lsuGnt) begin
        r_lsuSrc <= w_unmapped ? SRC_ERR : (w_hitI ? SRC_ITCM : SRC_DTCM);
        r_lsuHi  <= bus.lsu_addr[2];
        r_lsuWr  <= bus.lsu_we;
      end
      // Counts consecutive denials of a waiting fetch, saturating at the win threshold.
      if (!bus.if_req || w_ifGnt) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != 8'(STARVE_MAX)) begin
        r_starveCnt <= r_starveCnt + 8'd1;
      end
    end
  end

  always_comb begin
    bus.if_rvalid  = r_ifPend;
    bus.if_rdata   = r_ifPend ? bus.itcm_dout : '0;
    bus.lsu_rvalid = r_lsuPend;
    bus.lsu_rdata  = '0;
    if (r_lsuPend && !r_lsuWr) begin
      case (r_lsuSrc)
        SRC_ITCM: bus.lsu_rdata = r_lsuHi ? bus.itcm_dout[63:32] : bus.itcm_dout[31:0];
        SRC_DTCM: bus.lsu_rdata = bus.dtcm_dout;
        default:  bus.lsu_rdata = '0;
      endcase
    end
  end

`ifdef TCM_XBAR_ERR_EN
  assign bus.lsu_err = r_lsuPend && (r_lsuSrc == SRC_ERR);
`else
  assign bus.lsu_err = 1'b0;
`endif

endmodule

// File: doc/tcm_xbar.md
Name: tcm_xbar

Overview:
- Parametrised 2-master / 2-slave TCM interconnect that sits between the core's fetch and load/store ports and the ITCM (64-bit) and DTCM (32-bit) SRAM macros.
- Adds request/grant handshakes, read-valid tracking, starvation-bounded arbitration on ITCM collisions, and an error response for unmapped LSU accesses.
- Replaces ad-hoc top-level TCM muxing; region bases and SRAM depths are parameters.

Parameters:
- BASE_W, 8, number of upper address bits compared for region decode (lsu_addr[31:32-BASE_W]).
- ITCM_BASE, 8'h80, ITCM region tag.
- DTCM_BASE, 8'h90, DTCM region tag.
- ITCM_AW, 16, ITCM word address width (64-bit words).
- DTCM_AW, 16, DTCM word address width (32-bit words).
- STARVE_MAX, 4, consecutive fetch denials after which fetch wins one ITCM cycle; legal range 1..255.

Ports:
- clk  in  1  clock.
- cpurst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request (read only, always targets ITCM).
- if_addr  in  29  fetch address [31:3].
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  64  fetch data.
- lsu_req  in  1  LSU request.
- lsu_we  in  1  LSU write.
- lsu_addr  in  32  LSU byte address.
- lsu_ben  in  4  LSU byte enables.
- lsu_wdata  in  32  LSU write data.
- lsu_gnt  out  1  LSU accepted this cycle.
- lsu_rvalid  out  1  LSU response valid (read data or write ack).
- lsu_rdata  out  32  LSU read data.
- lsu_err  out  1  LSU response is a bus error.
- itcm_csn0  out  1  ITCM low-half chip select, active-low.
- itcm_csn1  out  1  ITCM high-half chip select, active-low.
- itcm_wen  out  1  ITCM write enable, active-low.
- itcm_addr  out  ITCM_AW  ITCM word address.
- itcm_ben  out  8  ITCM byte enables.
- itcm_din  out  64  ITCM write data.
- itcm_dout  in  64  ITCM read data, one-cycle latency.
- dtcm_csn  out  1  DTCM chip select, active-low.
- dtcm_wen  out  1  DTCM write enable, active-low.
- dtcm_addr  out  DTCM_AW  DTCM word address.
- dtcm_ben  out  4  DTCM byte enables.
- dtcm_din  out  32  DTCM write data.
- dtcm_dout  in  32  DTCM read data, one-cycle latency.

Behaviour:
- Decode is combinational on lsu_addr tag. Results: hit_i, hit_d, or unmapped.
- Grants are combinational, issued in the same cycle as the request. Masters must hold req/address stable until granted.
- lsu_gnt = lsu_req unless (hit_i and fetch wins).
- if_gnt = if_req unless (lsu_req and hit_i and fetch does not win).
- Fetch wins an ITCM collision only when starve_cnt == STARVE_MAX.
- starve_cnt:
  - increments on each cycle fetch is denied;
  - clears on any fetch grant or when if_req is low;
  - saturates at STARVE_MAX.
- ITCM port, LSU granted:
  - addr = lsu_addr[ITCM_AW+2:3];
  - csn0 active iff !lsu_addr[2], csn1 active iff lsu_addr[2];
  - ben = lsu_ben in the selected half, 0 in the other;
  - din = {lsu_wdata, lsu_wdata}.
- ITCM port, fetch granted: both halves selected, ben 8'hff, wen high, din 0.
- ITCM port, idle: csn high, addr/ben/din 0.
- DTCM port, LSU granted and hit_d: addr = lsu_addr[DTCM_AW+1:2]. Otherwise csn/wen high and addr/ben/din 0.
- Response pipeline: registered tags capture every granted access.
  - if_pend;
  - lsu_pend, lsu_src {ITCM, DTCM, ERR}, lsu_hi, lsu_wr.
- Cycle after grant:
  - if_rvalid=1, if_rdata=itcm_dout.
  - lsu_rvalid=1 for both reads and writes.
  - LSU read: lsu_rdata = ITCM half selected by lsu_hi, or dtcm_dout.
  - LSU write: lsu_rdata = 0.
- Both masters may be granted in the same cycle only when the LSU targets DTCM or is unmapped. Both rvalids then assert the next cycle.
- Back-to-back grants produce back-to-back rvalids. No internal buffering; throughput is 1 access per master per cycle.
- Unmapped LSU access: see Optional Feature.
- Reset, synchronous on cpurst: all tags, starve_cnt, if_rvalid, lsu_rvalid, lsu_err go 0; rdata outputs 0.
- Reset mid-operation drops pending responses. Grants are forced 0 while cpurst is high.

Optional Feature:
- Macro TCM_XBAR_ERR_EN.
- Defined: unmapped LSU access is granted without touching any SRAM. Next cycle lsu_rvalid=1, lsu_err=1, lsu_rdata=0.
- Undefined: unmapped accesses alias to DTCM (decoded as hit_d). lsu_err is tied 0.

Test Plan:
- Reset: hold cpurst 3 cycles with if_req=1 -> if_gnt=0, all rvalids 0, starve_cnt 0; first post-reset fetch at 0x8000_0008 -> if_rvalid next cycle with itcm_dout.
- DTCM store 0xDEADBEEF to 0x9000_0010 with ben 4'b0011, then load -> dtcm_addr=4, lsu_rvalid each cycle after grant, readback 0x0000BEEF in the bench SRAM model.
- Concurrent fetch + LSU load 0x9000_0000 -> both granted same cycle, both rvalid next cycle.
- ITCM collision, LSU load 0x8000_0004 every cycle with if_req=1, STARVE_MAX=4 -> fetch denied 4 cycles, granted on cycle 5 with lsu_gnt=0, pattern repeats.
- LSU load 0x8000_0004 -> csn1=0, csn0=1; lsu_rdata = itcm_dout[63:32].
- With TCM_XBAR_ERR_EN, load 0x4000_0000 -> no SRAM select, lsu_err=1, lsu_rdata=0. Without the macro -> DTCM access at dtcm_addr=0, lsu_err=0.
